// File: rtl/mem_pipe_test_server.sv
// mem_pipe_test_server: parametrised memory server for test benches.
// Reads and byte-masked writes execute at the accept edge. Responses travel
// through a fixed-latency pipeline into an in-order response FIFO, and
// request credits bound pipeline plus FIFO occupancy so nothing overflows.
// Optional macro MEM_PIPE_TEST_SERVER_STALL_EN adds LFSR-driven random
// stalls on both the request and response sides.
module mem_pipe_test_server #(
    parameter int unsigned p_opaq_bits  = 8,
    parameter int unsigned p_data_bits  = 32,
    parameter int unsigned p_mem_words  = 256,
    parameter int unsigned p_latency    = 2,
    parameter int unsigned p_resp_depth = 4,
    parameter logic [7:0]  p_seed       = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic                     req_op,
    input  logic [p_opaq_bits-1:0]   req_opaque,
    input  logic [31:0]              req_addr,
    input  logic [p_data_bits/8-1:0] req_len,
    input  logic [p_data_bits-1:0]   req_data,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     resp_op,
    output logic [p_opaq_bits-1:0]   resp_opaque,
    output logic [31:0]              resp_addr,
    output logic [p_data_bits/8-1:0] resp_len,
    output logic [p_data_bits-1:0]   resp_data
);

    localparam int unsigned MB = p_data_bits / 8;
    localparam int unsigned IW = $clog2(p_mem_words);
    localparam int unsigned PW = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
    localparam int unsigned CW = $clog2(p_resp_depth + 1);

    typedef struct packed {
        logic                   op;
        logic [p_opaq_bits-1:0] opaque;
        logic [31:0]            addr;
        logic [MB-1:0]          len;
        logic [p_data_bits-1:0] data;
    } resp_t;

    logic [p_data_bits-1:0] mem_q [p_mem_words];
    logic [p_mem_words-1:0] written_q;

    logic [IW-1:0]          idx;
    logic [p_data_bits-1:0] old_word;
    logic [p_data_bits-1:0] merged_word;
    logic                   accept;
    resp_t                  new_entry;

    logic                   push;
    resp_t                  push_entry;
    logic                   pop;

    resp_t                  fifo_q [p_resp_depth];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          occ_q, occ_d;
    logic                   rdy_q, rdy_d;
    logic                   val_q, val_d;
    resp_t                  head;

`ifdef MEM_PIPE_TEST_SERVER_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;
    localparam logic RDY_RST = (p_seed[1:0] != 2'b00);
`else
    localparam logic RDY_RST = 1'b1;
`endif

    assign accept = req_val & rdy_q;
    assign pop    = val_q & resp_rdy;
    assign idx    = req_addr[2 +: IW];

    // Current word (unwritten words read as zero) and its byte-masked update
    always_comb begin
        old_word    = written_q[idx] ? mem_q[idx] : '0;
        merged_word = old_word;
        for (int unsigned i = 0; i < MB; i++) begin
            if (req_len[i]) merged_word[8*i +: 8] = req_data[8*i +: 8];
        end
        new_entry.op     = req_op;
        new_entry.opaque = req_opaque;
        new_entry.addr   = req_addr;
        new_entry.len    = req_len;
        new_entry.data   = req_op ? '0 : old_word;
    end

    // Word array: writes commit at the accept edge
    always_ff @(posedge clk) begin
        if (!rst && accept && req_op) mem_q[idx] <= merged_word;
    end

    // Per-word written bits, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= '0;
        end else if (accept && req_op) begin
            written_q[idx] <= 1'b1;
        end
    end

    // Latency pipeline: p_latency-1 register stages ahead of the FIFO
    generate
        if (p_latency > 1) begin : g_pipe
            localparam int unsigned NS = p_latency - 1;
            resp_t stg_q [NS];
            logic  vld_q [NS];

            // Stage valid bits shift every cycle
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < NS; i++) vld_q[i] <= 1'b0;
                end else begin
                    vld_q[0] <= accept;
                    for (int unsigned i = 1; i < NS; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            // Stage payloads follow the valid bits
            always_ff @(posedge clk) begin
                stg_q[0] <= new_entry;
                for (int unsigned i = 1; i < NS; i++) stg_q[i] <= stg_q[i-1];
            end

            assign push       = vld_q[NS-1];
            assign push_entry = stg_q[NS-1];
        end else begin : g_nopipe
            assign push       = accept;
            assign push_entry = new_entry;
        end
    endgenerate

    // Response FIFO storage
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    // Pointers, counts, credits and registered handshake outputs
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(p_resp_depth - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(p_resp_depth - 1)) ? '0 : rd_ptr_q + PW'(1);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        occ_d = occ_q + CW'(accept) - CW'(pop);
        rdy_d = (occ_d < CW'(p_resp_depth));
        val_d = (cnt_d != '0);
`ifdef MEM_PIPE_TEST_SERVER_STALL_EN
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (lfsr_d[1:0] == 2'b00) rdy_d = 1'b0;
        if (lfsr_d[3:2] == 2'b00) val_d = 1'b0;
`endif
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            occ_q    <= '0;
            rdy_q    <= RDY_RST;
            val_q    <= 1'b0;
`ifdef MEM_PIPE_TEST_SERVER_STALL_EN
            lfsr_q   <= p_seed;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            occ_q    <= occ_d;
            rdy_q    <= rdy_d;
            val_q    <= val_d;
`ifdef MEM_PIPE_TEST_SERVER_STALL_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    assign head        = fifo_q[rd_ptr_q];
    assign req_rdy     = rdy_q;
    assign resp_val    = val_q;
    assign resp_op     = head.op;
    assign resp_opaque = head.opaque;
    assign resp_addr   = head.addr;
    assign resp_len    = head.len;
    assign resp_data   = head.data;

    // Address bits outside the word index are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^{p_seed, req_addr[1:0], req_addr[31:IW+2]};

endmodule

// File: tb/tb_mem_pipe_test_server.sv
// Directed self-checking bench for mem_pipe_test_server (default parameters).
module tb_mem_pipe_test_server;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    logic        req_op;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [31:0] req_data;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_op;
    logic [7:0]  resp_opaque;
    logic [31:0] resp_addr;
    logic [3:0]  resp_len;
    logic [31:0] resp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_pipe_test_server dut (
        .clk         (clk),
        .rst         (rst),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_op      (req_op),
        .req_opaque  (req_opaque),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_data    (req_data),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_op     (resp_op),
        .resp_opaque (resp_opaque),
        .resp_addr   (resp_addr),
        .resp_len    (resp_len),
        .resp_data   (resp_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request with resp_rdy high; checks latency and every response field
    task automatic txn(input string tag, input logic op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] len,
                       input logic [7:0] opq, input logic [31:0] exp_data);
        int lat;
        chk({tag, "_rdy"}, 64'(req_rdy), 64'd1);
        req_val    = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_data   = data;
        req_len    = len;
        req_opaque = opq;
        step();
        req_val = 1'b0;
        lat = 1;
        while (!resp_val && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, "_lat"},  64'(lat),         64'd2);
        chk({tag, "_op"},   64'(resp_op),     64'(op));
        chk({tag, "_opq"},  64'(resp_opaque), 64'(opq));
        chk({tag, "_addr"}, 64'(resp_addr),   64'(addr));
        chk({tag, "_len"},  64'(resp_len),    64'(len));
        chk({tag, "_data"}, 64'(resp_data),   64'(exp_data));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, sent, got, gaps, seen;
        logic acc;

        rst        = 1'b1;
        req_val    = 1'b0;
        req_op     = 1'b0;
        req_opaque = '0;
        req_addr   = '0;
        req_len    = '0;
        req_data   = '0;
        resp_rdy   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            chk("idle_val", 64'(resp_val), 64'd0);
            chk("idle_rdy", 64'(req_rdy), 64'd1);
            step();
        end

        // Basic write/read, byte mask, unwritten word, aliasing
        resp_rdy = 1'b1;
        txn("wr1",   1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 8'h01, 32'h0);
        txn("rd1",   1'b0, 32'h10,  32'h0,        4'hF, 8'h02, 32'hDEADBEEF);
        txn("wrA",   1'b1, 32'h20,  32'h11223344, 4'hF, 8'h03, 32'h0);
        txn("wrB",   1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 8'h04, 32'h0);
        txn("rdB",   1'b0, 32'h20,  32'h0,        4'hF, 8'h05, 32'h11BB33DD);
        txn("rdZ",   1'b0, 32'h40,  32'h0,        4'hF, 8'h06, 32'h0);
        txn("alias", 1'b0, 32'h413, 32'h0,        4'hF, 8'h07, 32'hDEADBEEF);

        // Backpressure: credits cap accepts at 4
        resp_rdy = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            acc        = req_rdy;
            req_val    = 1'b1;
            req_op     = 1'b0;
            req_addr   = 32'h10;
            req_len    = 4'hF;
            req_opaque = 8'h20 + 8'(k);
            step();
            if (acc) k++;
        end
        req_val = 1'b0;
        chk("bp_accepts", 64'(k), 64'd4);
        chk("bp_rdy_low", 64'(req_rdy), 64'd0);
        resp_rdy = 1'b1;
        for (int n = 0; n < 4; n++) begin
            chk("bp_val",  64'(resp_val), 64'd1);
            chk("bp_opq",  64'(resp_opaque), 64'(8'h20 + 8'(n)));
            chk("bp_data", 64'(resp_data), 64'hDEADBEEF);
            step();
            if (n == 0) chk("bp_rdy_reassert", 64'(req_rdy), 64'd1);
        end
        chk("bp_drained", 64'(resp_val), 64'd0);

        // Back-to-back reads at full rate
        sent = 0;
        got  = 0;
        gaps = 0;
        for (int c = 0; c < 40 && got < 16; c++) begin
            if (resp_val) begin
                chk("b2b_opq",  64'(resp_opaque), 64'(got));
                chk("b2b_data", 64'(resp_data), 64'hDEADBEEF);
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            if (sent < 16) begin
                acc        = req_rdy;
                req_val    = 1'b1;
                req_op     = 1'b0;
                req_addr   = 32'h10;
                req_len    = 4'hF;
                req_opaque = 8'(sent);
            end else begin
                acc     = 1'b0;
                req_val = 1'b0;
            end
            step();
            if (acc) sent++;
        end
        req_val = 1'b0;
        chk("b2b_sent",  64'(sent), 64'd16);
        chk("b2b_count", 64'(got),  64'd16);
        chk("b2b_gaps",  64'(gaps), 64'd0);

        // Mid-flight reset discards outstanding work and written bits
        resp_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_val    = 1'b1;
            req_op     = 1'b0;
            req_addr   = 32'h10;
            req_len    = 4'hF;
            req_opaque = 8'h40 + 8'(c);
            step();
        end
        req_val = 1'b0;
        rst     = 1'b1;
        step();
        rst      = 1'b0;
        resp_rdy = 1'b1;
        chk("rst_rdy", 64'(req_rdy), 64'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_val) seen++;
            step();
        end
        chk("rst_no_resp", 64'(seen), 64'd0);
        txn("rst_rd", 1'b0, 32'h10, 32'h0, 4'hF, 8'h50, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
